// File: rtl/nes_pad_reader_if.sv
// Pad-side signal bundle of the NES gamepad reader.
// The reader drives the strobes and the button byte; the pad/consumer side drives serial data.
interface nes_pad_reader_if;
   logic       I_DATA;
   logic       O_LATCH;
   logic       O_PULSE;
   logic [7:0] O_BUTTONS;
   logic       O_FRAME_DONE;
   logic       O_BUSY;

   modport master (
      input  I_DATA,
      output O_LATCH,
      output O_PULSE,
      output O_BUTTONS,
      output O_FRAME_DONE,
      output O_BUSY
   );

   modport slave (
      output I_DATA,
      input  O_LATCH,
      input  O_PULSE,
      input  O_BUTTONS,
      input  O_FRAME_DONE,
      input  O_BUSY
   );
endinterface

// File: rtl/nes_pad_reader.sv
// Serial front end for an NES-style gamepad: strobes LATCH/PULSE, shifts in 8 buttons and
// publishes an optionally debounced active-low byte {START,SELECT,B,A,DOWN,UP,LEFT,RIGHT}.
module nes_pad_reader #(
   parameter int unsigned P_TICK_CYCLES   = 198,
   parameter int unsigned P_POLL_TICKS    = 2778,
   parameter int unsigned P_REQUIRE_MATCH = 1
) (
   input  logic                    I_CLK,
   input  logic                    I_RESET,
   nes_pad_reader_if.master        io_pad
);

   localparam int unsigned LP_TICK_W = (P_TICK_CYCLES > 1) ? $clog2(P_TICK_CYCLES) : 1;
   localparam int unsigned LP_POLL_W = $clog2(P_POLL_TICKS + 1);
   localparam logic [LP_TICK_W-1:0] LP_TICK_MAX = LP_TICK_W'(P_TICK_CYCLES - 1);
   localparam logic [LP_POLL_W-1:0] LP_POLL_MAX = LP_POLL_W'(P_POLL_TICKS - 1);
   localparam bit LP_MATCH = (P_REQUIRE_MATCH != 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Pad shifts A,B,SELECT,START,UP,DOWN,LEFT,RIGHT; map shift index to output bit position.
   function automatic logic [2:0] f_map(input logic [2:0] i_idx);
      case (i_idx)
         3'd0:    f_map = 3'd4;
         3'd1:    f_map = 3'd5;
         3'd2:    f_map = 3'd6;
         3'd3:    f_map = 3'd7;
         3'd4:    f_map = 3'd2;
         3'd5:    f_map = 3'd3;
         3'd6:    f_map = 3'd1;
         default: f_map = 3'd0;
      endcase
   endfunction

   logic [1:0]           r_sync;
   logic [LP_TICK_W-1:0] r_tick_cnt;
   logic [LP_POLL_W-1:0] r_poll_cnt;
   logic [2:0]           r_bit_idx;
   logic                 r_phase;
   state_t               r_state;
   logic [7:0]           r_raw;
   logic [7:0]           r_prev;
   logic [7:0]           r_buttons;
   logic                 r_latch;
   logic                 r_pulse;
   logic                 r_frame_done;
   logic                 r_busy;

   logic                 w_tick;
   logic                 w_sync_data;
   state_t               w_state_nxt;
   logic [LP_POLL_W-1:0] w_poll_nxt;
   logic [2:0]           w_bit_idx_nxt;
   logic                 w_phase_nxt;
   logic [7:0]           w_raw_nxt;
   logic [7:0]           w_prev_nxt;
   logic [7:0]           w_buttons_nxt;

   assign w_tick      = (r_tick_cnt == LP_TICK_MAX);
   assign w_sync_data = r_sync[1];

   // Free-running protocol tick divider and input synchronizer
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         r_tick_cnt <= '0;
         r_sync     <= 2'b11;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + LP_TICK_W'(1);
         r_sync     <= {r_sync[0], io_pad.I_DATA};
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_poll_nxt    = r_poll_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_phase_nxt   = r_phase;
      w_raw_nxt     = r_raw;
      w_prev_nxt    = r_prev;
      w_buttons_nxt = r_buttons;
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               if (r_poll_cnt == LP_POLL_MAX) begin
                  w_poll_nxt  = '0;
                  w_state_nxt = S_LATCH;
               end else begin
                  w_poll_nxt  = r_poll_cnt + LP_POLL_W'(1);
               end
            end
         end
         S_LATCH: begin
            if (w_tick) begin
               if (r_phase) begin
                  w_phase_nxt   = 1'b0;
                  w_bit_idx_nxt = 3'd0;
                  w_state_nxt   = S_LOW;
               end else begin
                  w_phase_nxt   = 1'b1;
               end
            end
         end
         S_LOW: begin
            if (w_tick) begin
               w_raw_nxt[f_map(r_bit_idx)] = w_sync_data;
               w_state_nxt = (r_bit_idx == 3'd7) ? S_DONE : S_HIGH;
            end
         end
         S_HIGH: begin
            if (w_tick) begin
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               w_state_nxt   = S_LOW;
            end
         end
         S_DONE: begin
            // Debounce: publish only when two consecutive frames agree
            if (!LP_MATCH || (r_raw == r_prev)) begin
               w_buttons_nxt = r_raw;
            end
            w_prev_nxt  = r_raw;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Strobes decoded from next state so they line up with the state register
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         r_state      <= S_IDLE;
         r_poll_cnt   <= '0;
         r_bit_idx    <= 3'd0;
         r_phase      <= 1'b0;
         r_raw        <= 8'hFF;
         r_prev       <= 8'hFF;
         r_buttons    <= 8'hFF;
         r_latch      <= 1'b0;
         r_pulse      <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_poll_cnt   <= w_poll_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_phase      <= w_phase_nxt;
         r_raw        <= w_raw_nxt;
         r_prev       <= w_prev_nxt;
         r_buttons    <= w_buttons_nxt;
         r_latch      <= (w_state_nxt == S_LATCH);
         r_pulse      <= (w_state_nxt == S_HIGH);
         r_frame_done <= (w_state_nxt == S_DONE);
         r_busy       <= (w_state_nxt != S_IDLE);
      end
   end

   assign io_pad.O_LATCH      = r_latch;
   assign io_pad.O_PULSE      = r_pulse;
   assign io_pad.O_BUTTONS    = r_buttons;
   assign io_pad.O_FRAME_DONE = r_frame_done;
   assign io_pad.O_BUSY       = r_busy;

endmodule
